// File: rtl/sqrt_ctrl_pkg.sv
// Shared definitions for the square-root sequencing controller:
// state encoding, iteration counter width and default watchdog limit.
package sqrt_ctrl_pkg;

    localparam int          ITER_W       = 9;
    localparam int unsigned MAX_ITER_DEF = 256;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ITER_LO = 3'd2,
        ITER_HI = 3'd3,
        FIX     = 3'd4,
        DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/sqrt_pipe_ctrl.sv
// Sequencing controller for the two-stage integer square-root datapath:
// load, two-cycle iterations until the less-than flag, root fix, done.
module sqrt_pipe_ctrl
    import sqrt_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              N_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              wr_input_o,
    output logic              wr_square_o,
    output logic              en_pipe_o,
    output logic              ready_o,
    output logic              mux_root_o
);

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_e            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              ovf_q, ovf_d;
    logic [ITER_W-1:0] iter_inc;

    logic busy_q, done_q, ready_q, mux_root_q;
    logic wr_input_q, wr_square_q, en_pipe_q;

    assign iter_inc = iter_q + ITER_W'(1);

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    iter_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD:    state_d = ITER_LO;
            ITER_LO: state_d = ITER_HI;
            ITER_HI: begin
                // Every ITER_HI finishes one iteration, including the last one.
                if (iter_q != MAX_CNT) begin
                    iter_d = iter_inc;
                end
                if (N_i) begin
                    state_d = FIX;
                end else if (iter_inc == MAX_CNT) begin
                    ovf_d   = 1'b1;
                    state_d = FIX;
                end else begin
                    state_d = ITER_LO;
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore strobes are registered from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            mux_root_q  <= 1'b0;
            wr_input_q  <= 1'b0;
            wr_square_q <= 1'b0;
            en_pipe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            ovf_q       <= ovf_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            ready_q     <= (state_d == FIX) || (state_d == DONE);
            mux_root_q  <= (state_d == FIX);
            wr_input_q  <= (state_d == LOAD);
            wr_square_q <= (state_d == LOAD) || (state_d == FIX);
            en_pipe_q   <= (state_d == LOAD) || (state_d == ITER_LO) || (state_d == FIX);
        end
    end

    // The ITER_HI write-back depends on N_i, which the datapath already registers.
    logic iter_wb;
    assign iter_wb = (state_q == ITER_HI) && !N_i && (iter_inc != MAX_CNT);

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ovf_o       = ovf_q;
    assign iter_o      = iter_q;
    assign ready_o     = ready_q;
    assign mux_root_o  = mux_root_q;
    assign wr_input_o  = wr_input_q;
    assign wr_square_o = wr_square_q | iter_wb;
    assign en_pipe_o   = en_pipe_q | iter_wb;

endmodule
